// File: rtl/sdram_cache_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the SDRAM read cache: size encodings, FSM states
// and the byte-lane mask helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sdram_cache_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE,
        RESP,
        RELEASE
    } state_t;

    // Byte lanes touched by an access. Lanes shifted past byte 3 are dropped,
    // so a misaligned half/word only updates the lanes inside this word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/sdram_read_cache_if.sv
`timescale 1ns/1ps
// CPU-style memory bus shared by the CPU side and the SDRAM controller side.
// Latency: n/a (wires only).
// Backpressure: requester holds rw_req until the one-cycle data_valid pulse.
// Signals: address/rw_req/rw/write_data/size from requester, read_data/data_valid back.
interface sdram_read_cache_if;
    logic [31:0] address;
    logic        rw_req;
    logic        rw;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic [31:0] read_data;
    logic        data_valid;

    modport master (
        output address, rw_req, rw, write_data, size,
        input  read_data, data_valid
    );

    modport slave (
        input  address, rw_req, rw, write_data, size,
        output read_data, data_valid
    );
endinterface

// File: rtl/cache_line_ram.sv
`timescale 1ns/1ps
// Tag + data storage for the cache lines: synchronous single-port RAM.
// Latency: 1 cycle read (o_tag/o_data valid the cycle after i_index).
// Backpressure: none; one access per cycle, write has byte enables on data.
// Ports: clk, i_we, i_be[3:0], i_index, i_tag, i_data -> o_tag, o_data.
module cache_line_ram #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [TAG_BITS-1:0]   i_tag,
    input  logic [31:0]           i_data,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic [31:0]           o_data
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0] r_tag_mem  [DEPTH];
    logic [3:0][7:0]     r_data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag_mem[i_index] <= i_tag;
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_data_mem[i_index][b] <= i_data[8*b +: 8];
                end
            end
        end
        o_tag  <= r_tag_mem[i_index];
        o_data <= r_data_mem[i_index];
    end

endmodule

// File: rtl/sdram_read_cache.sv
`timescale 1ns/1ps
// Direct-mapped write-through single-word-line cache in front of the SDRAM controller.
// Latency: read hit data_valid 2 cycles after rw_req is sampled; misses/writes wait on the controller.
// Backpressure: CPU holds rw_req until data_valid; one controller request per transaction.
// Ports: clk, reset (async active-low), cpu (slave bus), mem (master bus to controller).
// Optional macro SDRAM_CACHE_STATS_EN adds hit_count/miss_count outputs.
module sdram_read_cache
    import sdram_cache_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_BITS  = 32
) (
    input  logic               clk,
    input  logic               reset,
    sdram_read_cache_if.slave  cpu,
    sdram_read_cache_if.master mem
`ifdef SDRAM_CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
    localparam int NLINES   = 1 << INDEX_BITS;

    state_t r_state;
    state_t w_next;

    logic [31:0]       r_addr;
    logic              r_rw;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_hit;
    logic [31:0]       r_word;
    logic [NLINES-1:0] r_valid;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_ram_index;
    logic                  w_ram_we;
    logic [3:0]            w_ram_be;
    logic [31:0]           w_ram_wdata;
    logic [TAG_BITS-1:0]   w_ram_tag_q;
    logic [31:0]           w_ram_data_q;
    logic                  w_lookup_hit;
    logic [31:0]           w_rd_shift;
    logic [31:0]           w_rd_data;

    assign w_idx = r_addr[INDEX_BITS+1:2];
    assign w_tag = r_addr[ADDR_BITS-1:INDEX_BITS+2];

    // In IDLE the RAM is addressed straight from the CPU bus so the tag/data
    // are ready during LOOKUP; afterwards the latched address holds the index.
    assign w_ram_index  = (r_state == IDLE) ? cpu.address[INDEX_BITS+1:2] : w_idx;
    assign w_lookup_hit = r_valid[w_idx] && (w_ram_tag_q == w_tag);

    // Fills write the whole word; write hits merge only the addressed lanes.
    assign w_ram_we    = mem.data_valid && ((r_state == FILL) || ((r_state == WRITE) && r_hit));
    assign w_ram_be    = (r_state == FILL) ? 4'hF : lane_mask(r_size, r_addr[1:0]);
    assign w_ram_wdata = (r_state == FILL) ? mem.read_data : (r_wdata << {r_addr[1:0], 3'b000});

    cache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_index (w_ram_index),
        .i_tag   (w_tag),
        .i_data  (w_ram_wdata),
        .o_tag   (w_ram_tag_q),
        .o_data  (w_ram_data_q)
    );

    // Read data: shift addressed byte down to bit 0, then zero-extend by size.
    assign w_rd_shift = r_word >> {r_addr[1:0], 3'b000};
    always_comb begin
        case (r_size)
            SZ_BYTE: w_rd_data = {24'h0, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = {16'h0, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cpu.rw_req) w_next = LOOKUP;
            LOOKUP:  w_next = r_rw ? WRITE : (w_lookup_hit ? RESP : FILL);
            FILL:    if (mem.data_valid) w_next = RESP;
            WRITE:   if (mem.data_valid) w_next = RESP;
            RESP:    w_next = RELEASE;
            // Waiting for rw_req low stops a still-held request from retriggering.
            RELEASE: if (!cpu.rw_req) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem.rw_req     = 1'b0;
        mem.rw         = 1'b0;
        mem.address    = 32'h0;
        mem.write_data = 32'h0;
        mem.size       = SZ_BYTE;
        cpu.data_valid = 1'b0;
        cpu.read_data  = 32'h0;
        case (r_state)
            FILL: begin
                mem.rw_req  = 1'b1;
                mem.address = {r_addr[31:2], 2'b00};
                mem.size    = SZ_WORD;
            end
            WRITE: begin
                mem.rw_req     = 1'b1;
                mem.rw         = 1'b1;
                mem.address    = r_addr;
                mem.write_data = r_wdata;
                mem.size       = r_size;
            end
            RESP: begin
                cpu.data_valid = 1'b1;
                if (!r_rw) cpu.read_data = w_rd_data;
            end
            default: ;
        endcase
    end

    // Request latch, lookup result and line valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= 32'h0;
            r_rw    <= 1'b0;
            r_wdata <= 32'h0;
            r_size  <= SZ_BYTE;
            r_hit   <= 1'b0;
            r_word  <= 32'h0;
            r_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu.rw_req) begin
                        r_addr  <= cpu.address;
                        r_rw    <= cpu.rw;
                        r_wdata <= cpu.write_data;
                        r_size  <= cpu.size;
                    end
                end
                LOOKUP: begin
                    r_hit  <= w_lookup_hit;
                    r_word <= w_ram_data_q;
                end
                FILL: begin
                    if (mem.data_valid) begin
                        r_word         <= mem.read_data;
                        r_valid[w_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else if ((r_state == LOOKUP) && !r_rw) begin
            if (w_lookup_hit) begin
                if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'h1;
            end else begin
                if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'h1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_sdram_read_cache.sv
`timescale 1ns/1ps
module tb_sdram_read_cache;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_read_cache_if cpu_if ();
    sdram_read_cache_if mem_if ();

`ifdef SDRAM_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    sdram_read_cache #(
        .INDEX_BITS (8),
        .ADDR_BITS  (32)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cpu        (cpu_if.slave),
        .mem        (mem_if.master)
`ifdef SDRAM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: SDRAM contents plus which tag each index currently holds.
    logic [31:0] mem_model [logic [29:0]];
    bit          mv [256];
    logic [21:0] mt [256];
    int          m_hits   = 0;
    int          m_misses = 0;

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        logic [31:0] t;
        if (mem_model.exists(wa)) return mem_model[wa];
        t = {2'b00, wa};
        return (t * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] fmt_read(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (i < 4 - off && i < nbytes(sz)) r[8*i +: 8] = w[8*(i+off) +: 8];
            else r[8*i +: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nbytes(sz)) r[8*i +: 8] = wd[8*(i-off) +: 8];
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // One CPU transaction with the bench acting as the SDRAM controller.
    task automatic txn(input logic [31:0] addr, input logic rw, input logic [1:0] sz,
                       input logic [31:0] wd, input int lat, input int hold, input bit early,
                       output logic [31:0] rd, output int reqs, output int dv_cyc);
        logic [7:0]  idx;
        logic [21:0] tag;
        bit          exp_hit;
        logic [31:0] exp_rd;
        logic [66:0] exp_f;
        int          cyc;
        int          cnt;
        bit          prev_req;
        bit          serving;
        bit          got;
        bit          quiet;
        idx     = addr[9:2];
        tag     = addr[31:10];
        exp_hit = !rw && mv[idx] && (mt[idx] == tag);
        exp_rd  = rw ? 32'h0 : fmt_read(mem_rd(addr[31:2]), addr[1:0], sz);
        exp_f   = {rw, (rw ? addr : {addr[31:2], 2'b00}), (rw ? sz : 2'b10), (rw ? wd : 32'h0)};
        rd = 32'h0; reqs = 0; dv_cyc = 0;
        cyc = 0; cnt = 0; prev_req = 0; serving = 0; got = 0;

        @(posedge clk); #1;
        cpu_if.address    = addr;
        cpu_if.rw         = rw;
        cpu_if.size       = sz;
        cpu_if.write_data = wd;
        cpu_if.rw_req     = 1'b1;

        while (!got && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            mem_if.data_valid = 1'b0;
            if (early && cyc == 1) cpu_if.rw_req = 1'b0;
            if (mem_if.rw_req && !prev_req) begin
                reqs++;
                serving = 1;
                cnt     = lat;
                n_total++;
                if ({mem_if.rw, mem_if.address, mem_if.size, mem_if.write_data} !== exp_f) begin
                    $display("FAIL req_fields addr=%h: got %h want %h", addr,
                             {mem_if.rw, mem_if.address, mem_if.size, mem_if.write_data}, exp_f);
                end else n_pass++;
            end
            prev_req = mem_if.rw_req;
            if (cpu_if.data_valid) begin
                got    = 1;
                rd     = cpu_if.read_data;
                dv_cyc = cyc;
            end else if (serving && mem_if.rw_req) begin
                if (cnt == 0) begin
                    mem_if.data_valid = 1'b1;
                    mem_if.read_data  = rw ? $urandom : mem_rd(addr[31:2]);
                    serving = 0;
                end else cnt--;
            end
        end

        n_total++;
        if (!got) $display("FAIL completion addr=%h: no data_valid within %0d cycles", addr, cyc);
        else n_pass++;

        n_total++;
        if (reqs != (exp_hit ? 0 : 1)) $display("FAIL req_count addr=%h: got %0d want %0d", addr, reqs, exp_hit ? 0 : 1);
        else n_pass++;

        n_total++;
        if (rd !== exp_rd) $display("FAIL read_data addr=%h size=%b: got %h want %h", addr, sz, rd, exp_rd);
        else n_pass++;

        if (exp_hit) begin
            n_total++;
            if (dv_cyc != 2) $display("FAIL hit_latency addr=%h: got %0d want 2", addr, dv_cyc);
            else n_pass++;
        end

        // data_valid must be a single pulse and a held request must not retrigger.
        quiet = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (cpu_if.data_valid || mem_if.rw_req) quiet = 0;
        end
        cpu_if.rw_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (cpu_if.data_valid || mem_if.rw_req) quiet = 0;
        end
        n_total++;
        if (!quiet) $display("FAIL quiet_after addr=%h: got activity want none", addr);
        else n_pass++;

        if (rw) mem_model[addr[31:2]] = merge(mem_rd(addr[31:2]), wd, addr[1:0], sz);
        else begin
            if (exp_hit) m_hits++;
            else begin
                m_misses++;
                mv[idx] = 1'b1;
                mt[idx] = tag;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        cpu_if.rw_req     = 1'b0;
        mem_if.data_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({cpu_if.data_valid, cpu_if.read_data, mem_if.rw_req, mem_if.rw, mem_if.address,
             mem_if.write_data, mem_if.size} !== '0)
            $display("FAIL reset_outputs: got nonzero output while in reset, want all 0");
        else n_pass++;
        do_reset();
        @(posedge clk); #1;
        n_total++;
        if ({cpu_if.data_valid, mem_if.rw_req} !== 2'b00)
            $display("FAIL post_reset_idle: got dv=%b mreq=%b want 0 0", cpu_if.data_valid, mem_if.rw_req);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        int reqs, dvc;
        mem_model[32'h0001_0040 >> 2] = 32'hDEAD_BEEF;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 5, 0, 0, rd, reqs, dvc);
        n_total++;
        if (rd !== 32'hDEAD_BEEF || reqs != 1) $display("FAIL cold_read: got %h/%0d want deadbeef/1", rd, reqs);
        else n_pass++;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 5, 0, 0, rd, reqs, dvc);
        n_total++;
        if (rd !== 32'hDEAD_BEEF || reqs != 0 || dvc != 2)
            $display("FAIL warm_read: got %h/%0d/%0d want deadbeef/0/2", rd, reqs, dvc);
        else n_pass++;
        txn(32'h0001_0041, 1'b1, 2'b00, 32'h0000_00AA, 2, 0, 0, rd, reqs, dvc);
        n_total++;
        if (rd !== 32'h0 || reqs != 1) $display("FAIL byte_write: got %h/%0d want 0/1", rd, reqs);
        else n_pass++;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 5, 0, 0, rd, reqs, dvc);
        n_total++;
        if (rd !== 32'hDEAD_AAEF || reqs != 0) $display("FAIL merged_read: got %h/%0d want deadaaef/0", rd, reqs);
        else n_pass++;
        txn(32'h0001_0440, 1'b0, 2'b10, 32'h0, 3, 0, 0, rd, reqs, dvc);
        n_total++;
        if (reqs != 1) $display("FAIL alias_fill: got %0d reqs want 1", reqs);
        else n_pass++;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 3, 0, 0, rd, reqs, dvc);
        n_total++;
        if (rd !== 32'hDEAD_AAEF || reqs != 1) $display("FAIL alias_evicted: got %h/%0d want deadaaef/1", rd, reqs);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int reqs, dvc;
        for (int i = 0; i < 4; i++) begin
            txn(32'h0001_0040 + (i << 2), 1'b0, 2'b10, 32'h0, 1, 4, 0, rd, reqs, dvc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        int reqs, dvc;
        logic [1:0] sz;
        for (int i = 0; i < 200; i++) begin
            addr = {20'h0, 2'($urandom_range(0, 2)), 5'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            sz   = 2'($urandom_range(0, 2));
            txn(addr, 1'($urandom_range(0, 2) == 0), sz, $urandom, $urandom_range(0, 6),
                $urandom_range(0, 2), 0, rd, reqs, dvc);
        end
    endtask

    task automatic test_early_drop();
        logic [31:0] rd;
        int reqs, dvc;
        txn(32'h0000_0808, 1'b0, 2'b01, 32'h0, 4, 0, 1, rd, reqs, dvc);
        txn(32'h0000_0808, 1'b0, 2'b10, 32'h0, 4, 0, 1, rd, reqs, dvc);
        txn(32'h0000_0809, 1'b1, 2'b00, 32'h0000_0055, 4, 0, 1, rd, reqs, dvc);
    endtask

    task automatic test_stray_mdv();
        logic [31:0] rd;
        int reqs, dvc;
        bit quiet;
        quiet = 1;
        @(posedge clk); #1;
        mem_if.data_valid = 1'b1;
        mem_if.read_data  = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_if.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (cpu_if.data_valid || mem_if.rw_req) quiet = 0;
        end
        n_total++;
        if (!quiet) $display("FAIL stray_mdv: got activity want none");
        else n_pass++;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 3, 0, 0, rd, reqs, dvc);
    endtask

    task automatic test_reset_fill();
        logic [31:0] rd;
        int reqs, dvc;
        bit seen;
        bit quiet;
        seen = 0;
        @(posedge clk); #1;
        cpu_if.address = 32'h0002_0080;
        cpu_if.rw      = 1'b0;
        cpu_if.size    = 2'b10;
        cpu_if.rw_req  = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_if.rw_req) seen = 1;
        end
        n_total++;
        if (!seen) $display("FAIL fill_start: got no m_rw_req want one");
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        cpu_if.rw_req = 1'b0;
        #1;
        n_total++;
        if ({cpu_if.data_valid, cpu_if.read_data, mem_if.rw_req, mem_if.rw, mem_if.address,
             mem_if.write_data, mem_if.size} !== '0)
            $display("FAIL reset_in_fill: got nonzero output want all 0");
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_if.data_valid = 1'b1;
        mem_if.read_data  = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mem_if.data_valid = 1'b0;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (cpu_if.data_valid || mem_if.rw_req) quiet = 0;
        end
        n_total++;
        if (!quiet) $display("FAIL late_mdv: got activity want none");
        else n_pass++;
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 3, 0, 0, rd, reqs, dvc);
        n_total++;
        if (reqs != 1 || rd !== 32'hDEAD_AAEF) $display("FAIL refill_after_reset: got %0d/%h want 1/deadaaef", reqs, rd);
        else n_pass++;
    endtask

`ifdef SDRAM_CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd;
        int reqs, dvc;
        do_reset();
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 2, 0, 0, rd, reqs, dvc);
        txn(32'h0001_0080, 1'b0, 2'b10, 32'h0, 2, 0, 0, rd, reqs, dvc);
        txn(32'h0001_0040, 1'b0, 2'b10, 32'h0, 2, 0, 0, rd, reqs, dvc);
        txn(32'h0001_0080, 1'b0, 2'b00, 32'h0, 2, 0, 0, rd, reqs, dvc);
        txn(32'h0001_0083, 1'b1, 2'b00, 32'h0000_0011, 2, 0, 0, rd, reqs, dvc);
        txn(32'h0001_0042, 1'b0, 2'b01, 32'h0, 2, 0, 0, rd, reqs, dvc);
        n_total++;
        if (hit_count !== 32'd3 || miss_count !== 32'd2)
            $display("FAIL stats: got hit=%0d miss=%0d want 3 2", hit_count, miss_count);
        else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cpu_if.address    = 32'h0;
        cpu_if.rw_req     = 1'b0;
        cpu_if.rw         = 1'b0;
        cpu_if.write_data = 32'h0;
        cpu_if.size       = 2'b00;
        mem_if.read_data  = 32'h0;
        mem_if.data_valid = 1'b0;
        model_reset();

        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_early_drop();
        test_stray_mdv();
        test_reset_fill();
`ifdef SDRAM_CACHE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdram_read_cache.md
Name: sdram_read_cache

Overview:
- Direct-mapped, write-through, single-word-line cache between the criscv CPU bus and the sdram controller.
- Consumes CPU requests that decode to the SDRAM region and produces requests on the controller's identical bus.
- Read hits return in 2 cycles with no SDRAM access. Misses fill one word; writes always pass through.

Parameters:
- INDEX_BITS, 8, line index width; number of lines = 2^INDEX_BITS.
- ADDR_BITS, 32, address width; tag = address[ADDR_BITS-1:INDEX_BITS+2].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address.
- rw_req  in  1  CPU request; held high until data_valid is seen.
- rw  in  1  1=write, 0=read.
- write_data  in  32  write data, right-justified.
- size  in  2  00=byte, 01=half, 10=word.
- read_data  out  32  CPU read data.
- data_valid  out  1  one-cycle completion pulse to the CPU.
- m_address  out  32  SDRAM controller address.
- m_rw_req  out  1  controller request.
- m_rw  out  1  controller direction.
- m_write_data  out  32  controller write data.
- m_size  out  2  controller size.
- m_read_data  in  32  controller read data.
- m_data_valid  in  1  controller completion pulse.

Behaviour:
- Reset (async, reset=0): all outputs 0; all valid bits cleared; FSM to IDLE. Any in-flight controller transaction is abandoned, and a later m_data_valid is ignored.
- Storage: per line, a valid bit (flops, async-cleared) plus tag and 32-bit data in a synchronous RAM with 1-cycle read.
- FSM states: IDLE, LOOKUP, FILL, WRITE, RESP, RELEASE.
- IDLE: on rw_req=1, latch address/rw/write_data/size, issue RAM read at index=address[INDEX_BITS+1:2], go to LOOKUP.
- LOOKUP, read:
  - hit (valid & tag match) -> RESP; data_valid is high in the 2nd cycle after rw_req is sampled.
  - miss -> FILL.
- LOOKUP, write: go to WRITE; record the hit flag.
- FILL:
  - Drive m_rw_req=1, m_rw=0, m_size=10, m_address={address[31:2],2'b00}; hold until m_data_valid.
  - On m_data_valid: write tag+data, set valid, go to RESP.
- WRITE:
  - Drive m_rw_req=1, m_rw=1, with address, size and write_data passed through unchanged; hold until m_data_valid.
  - On hit, merge the byte lanes selected by size and address[1:0] into the stored word. On miss, no allocate.
  - Then go to RESP.
- RESP:
  - data_valid=1 for exactly one cycle.
  - Read data = word >> (8*address[1:0]), masked to 8/16/32 bits per size and zero-extended.
  - Writes return read_data=0.
  - Go to RELEASE.
- RELEASE: wait for rw_req=0, then IDLE. This prevents a held request from retriggering.
- m_rw_req drops in the cycle after m_data_valid. The controller sees one request per transaction.
- Boundaries:
  - Misaligned half or word accesses are forwarded as-is; the cache update uses the truncated lane mask.
  - Index wrap aliases addresses 2^(INDEX_BITS+2) apart, and the tag distinguishes them.
  - rw_req dropping before completion is a protocol violation: the transaction still completes, and data_valid is still pulsed.
  - m_data_valid outside FILL or WRITE is ignored.

Optional Feature:
- Macro: SDRAM_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - Each increments once per read in LOOKUP; writes are not counted; both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package sdram_cache_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - function computing byte-lane mask from size and offset.
- Sub-module cache_line_ram: synchronous single-port RAM, depth 2^INDEX_BITS, width tag+32, with write-enable and per-byte data enables. Valid bits stay in the parent.

Test Plan:
- Cold read of word 0x0001_0040, SDRAM returning 0xDEADBEEF after 5 cycles -> one m_rw_req at 0x0001_0040 size 10, CPU data_valid with 0xDEADBEEF.
- Repeat the same read -> data_valid 2 cycles after rw_req, m_rw_req stays 0, read_data 0xDEADBEEF.
- Byte write 0xAA to 0x0001_0041, then word read -> write forwarded size 00; the read hits and returns 0xDEADAAEF with no fill.
- Read 0x0001_0440, which aliases index 0x10 -> miss, fill, line replaced; a following read of 0x0001_0040 misses again.
- Assert reset during FILL, then deassert and read 0x0001_0040 -> late m_data_valid is ignored, valid is clear, and a fresh fill is issued.
- With SDRAM_CACHE_STATS_EN, run 3 hits and 2 misses -> hit_count=3, miss_count=2.
